// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the RV32I data-memory path.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B    = 2'b00,
    MEM_H    = 2'b01,
    MEM_W    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'b00,
    DMEM_SECOND = 2'b01,
    DMEM_RESP   = 2'b10
  } dmem_state_e;

  function automatic logic [2:0] mem_size_bytes(mem_size_e size);
    case (size)
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Low-justified byte-enable mask for an access of the given size.
  function automatic logic [3:0] mem_size_mask(mem_size_e size);
    case (size)
      MEM_B:   return 4'b0001;
      MEM_H:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Byte k of the result is byte lane (k + off) mod 4 of w.
  function automatic logic [31:0] rot_right_bytes(logic [31:0] w, logic [1:0] off);
    logic [63:0] dbl;
    dbl = {w, w} >> {off, 3'b000};
    return dbl[31:0];
  endfunction

  // Inverse of rot_right_bytes: byte k of w lands on lane (k + off) mod 4.
  function automatic logic [31:0] rot_left_bytes(logic [31:0] w, logic [1:0] off);
    logic [63:0] dbl;
    dbl = {w, w} << {off, 3'b000};
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: load extension of assembled bytes and
// per-lane store data/masks for the first and second word of an access.
module dmem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [1:0]  off,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] rbytes,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_mask0,
  output logic [3:0]  lane_mask1,
  output logic [3:0]  hi_bytes
);

  logic [7:0] mask8;
  logic       sign_b;
  logic       sign_h;

  assign sign_b = ~is_unsigned & rbytes[7];
  assign sign_h = ~is_unsigned & rbytes[15];

  always_comb begin
    rdata = rbytes;
    case (size)
      MEM_B:   rdata = {{24{sign_b}}, rbytes[7:0]};
      MEM_H:   rdata = {{16{sign_h}}, rbytes[15:0]};
      default: rdata = rbytes;
    endcase
  end

  assign lane_wdata = rot_left_bytes(wdata, off);

  // Lanes that spill past lane 3 belong to the following word.
  assign mask8      = {4'b0000, mem_size_mask(size)} << off;
  assign lane_mask0 = mask8[3:0];
  assign lane_mask1 = mask8[7:4];

  // Access bytes k with off + k >= 4 come from the second word.
  assign hi_bytes = 4'b1111 << (3'd4 - {1'b0, off});

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store unit: one request at a time,
// valid/ready on both channels. Define DMEM_MISALIGN_SPLIT_EN to split
// word-crossing accesses over two cycles; otherwise misaligned accesses fault.
module dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32768,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [32:0] MemBytes = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_e      state_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;
  logic [1:0]       off_q;
  mem_size_e        size_q;
  logic             uns_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      hold_q;

  mem_size_e        req_sz;
  logic [2:0]       req_n;
  logic [32:0]      last_addr;
  logic             range_err;
  logic             misalign_err;
  logic             req_cross;
  logic             req_err;
  logic             is_idle;
  logic             accept;

  logic [1:0]       off_a;
  mem_size_e        size_a;
  logic             uns_a;
  logic [31:0]      wdata_a;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      rd_word;
  logic [31:0]      rd_rot;
  logic [31:0]      hi_mask;
  logic [31:0]      assembled;
  logic [31:0]      ext_rdata;
  logic [31:0]      lane_wdata;
  logic [3:0]       lane_mask0;
  logic [3:0]       lane_mask1;
  logic [3:0]       hi_bytes;
  logic             wr_en;
  logic [3:0]       wr_mask;

  // Request decode; 33-bit sum so an address near 2^32 cannot wrap into range.
  assign req_sz    = mem_size_e'(req_size);
  assign req_n     = mem_size_bytes(req_sz);
  assign last_addr = {1'b0, req_addr} + {30'b0, req_n} - 33'd1;
  assign range_err = last_addr >= MemBytes;

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign misalign_err = 1'b0;
  assign req_cross    = ({1'b0, req_addr[1:0]} + req_n) > 3'd4;
`else
  assign misalign_err = ((req_sz == MEM_H) && req_addr[0]) ||
                        ((req_sz == MEM_W) && (req_addr[1:0] != 2'b00));
  assign req_cross    = 1'b0;
`endif

  assign req_err = (req_sz == MEM_RSVD) || range_err || misalign_err;
  assign is_idle = (state_q == DMEM_IDLE);
  assign accept  = rst_n && req_valid && req_ready_q;

  // In IDLE the lane logic sees the live request; in SECOND the captured one.
  assign off_a   = is_idle ? req_addr[1:0] : off_q;
  assign size_a  = is_idle ? req_sz        : size_q;
  assign uns_a   = is_idle ? req_unsigned  : uns_q;
  assign wdata_a = is_idle ? req_wdata     : wdata_q;
  assign req_idx = req_addr[IDX_W+1:2];
  assign acc_idx = is_idle ? req_idx : idx_q + {{(IDX_W-1){1'b0}}, 1'b1};

  assign rd_word = mem[acc_idx];
  assign rd_rot  = rot_right_bytes(rd_word, off_a);
  assign hi_mask = {{8{hi_bytes[3]}}, {8{hi_bytes[2]}}, {8{hi_bytes[1]}}, {8{hi_bytes[0]}}};
  assign assembled = is_idle ? rd_rot : ((hold_q & ~hi_mask) | (rd_rot & hi_mask));

  dmem_lane_align u_lane_align (
    .off         (off_a),
    .size        (size_a),
    .is_unsigned (uns_a),
    .rbytes      (assembled),
    .wdata       (wdata_a),
    .rdata       (ext_rdata),
    .lane_wdata  (lane_wdata),
    .lane_mask0  (lane_mask0),
    .lane_mask1  (lane_mask1),
    .hi_bytes    (hi_bytes)
  );

  // Reset in SECOND suppresses the pending second-word write.
  assign wr_en   = (accept && req_we && !req_err) ||
                   (rst_n && (state_q == DMEM_SECOND) && we_q);
  assign wr_mask = is_idle ? lane_mask0 : lane_mask1;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_mask[b]) begin
        mem[acc_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DMEM_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      off_q       <= '0;
      size_q      <= MEM_B;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            off_q       <= req_addr[1:0];
            size_q      <= req_sz;
            uns_q       <= req_unsigned;
            we_q        <= req_we;
            wdata_q     <= req_wdata;
            idx_q       <= req_idx;
            hold_q      <= assembled;
            if (req_err) begin
              state_q     <= DMEM_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (req_cross) begin
              state_q <= DMEM_SECOND;
            end else begin
              state_q     <= DMEM_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= req_we ? 32'b0 : ext_rdata;
            end
          end
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        DMEM_SECOND: begin
          state_q     <= DMEM_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? 32'b0 : ext_rdata;
        end
`endif
        DMEM_RESP: begin
          if (rsp_ready) begin
            state_q     <= DMEM_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= DMEM_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (both DMEM_MISALIGN_SPLIT_EN builds).
module tb_dmem_responder;

  localparam int unsigned DEPTH_WORDS = 32768;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  // Issue one request, wait for the response; lat counts cycles from accept edge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int wait_cyc);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    lat = 0;
    rdata = 'x;
    err = 1'bx;
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h: req_ready stayed low, required high", addr);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 20);
      rdata = rsp_rdata;
      err = rsp_err;
      if (!rsp_valid) begin
        checks++; errors++;
        $display("FAIL rsp_timeout addr=%h: rsp_valid stayed low, required high", addr);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, required 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_word();
    logic [31:0] r; logic e; int l; int w;
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, r, e, l, w);
    checks++;
    if (e !== 1'b0 || l != 1 || r !== 32'h0) begin
      errors++;
      $display("FAIL st_word: err=%b lat=%0d rdata=%h, required 0 1 00000000", e, l, r);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, e, l, w);
    checks++;
    if (e !== 1'b0 || l != 1 || r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ld_word: err=%b lat=%0d rdata=%h, required 0 1 deadbeef", e, l, r);
    end
  endtask

  task automatic test_extension();
    logic [31:0] r; logic e; int l; int w;
    logic [31:0] addrs [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF,
                               32'hFFFFFFEF};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, r, e, l, w);
      checks++;
      if (e !== 1'b0 || r !== exps[i]) begin
        errors++;
        $display("FAIL ext_%0d addr=%h: err=%b rdata=%h, required 0 %h", i, addrs[i], e, r, exps[i]);
      end
    end
  endtask

  task automatic test_store_mask();
    logic [31:0] r; logic e; int l; int w;
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'hAABBCC55, r, e, l, w);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, e, l, w);
    checks++;
    if (r !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL st_byte_mask: rdata=%h, required dead55ef", r);
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h11223344, r, e, l, w);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, e, l, w);
    checks++;
    if (r !== 32'h334455EF) begin
      errors++;
      $display("FAIL st_half_mask: rdata=%h, required 334455ef", r);
    end
  endtask

  task automatic test_crossing();
    logic [31:0] r; logic e; int l; int w;
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h0, r, e, l, w);
    do_req(1'b1, 2'b10, 1'b0, 32'h204, 32'h0, r, e, l, w);
    do_req(1'b1, 2'b10, 1'b0, 32'h202, 32'h12345678, r, e, l, w);
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++;
    if (e !== 1'b0 || l != 2) begin
      errors++;
      $display("FAIL cross_store: err=%b lat=%0d, required 0 2", e, l);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, r, e, l, w);
    checks++;
    if (r !== 32'h56780000) begin
      errors++;
      $display("FAIL cross_word0: rdata=%h, required 56780000", r);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, r, e, l, w);
    checks++;
    if (r !== 32'h00001234) begin
      errors++;
      $display("FAIL cross_word1: rdata=%h, required 00001234", r);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h202, 32'h0, r, e, l, w);
    checks++;
    if (e !== 1'b0 || l != 2 || r !== 32'h12345678) begin
      errors++;
      $display("FAIL cross_load: err=%b lat=%0d rdata=%h, required 0 2 12345678", e, l, r);
    end
    do_req(1'b0, 2'b01, 1'b0, 32'h203, 32'h0, r, e, l, w);
    checks++;
    if (e !== 1'b0 || l != 2 || r !== 32'h00003456) begin
      errors++;
      $display("FAIL cross_half: err=%b lat=%0d rdata=%h, required 0 2 00003456", e, l, r);
    end
`else
    checks++;
    if (e !== 1'b1 || l != 1 || r !== 32'h0) begin
      errors++;
      $display("FAIL misalign_store: err=%b lat=%0d rdata=%h, required 1 1 00000000", e, l, r);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, r, e, l, w);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL misalign_word0: rdata=%h, required 00000000", r);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, r, e, l, w);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL misalign_word1: rdata=%h, required 00000000", r);
    end
    do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, r, e, l, w);
    checks++;
    if (e !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL misalign_half: err=%b rdata=%h, required 1 00000000", e, r);
    end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int l; int w;
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, r, e, l, w);
    checks++;
    if (e !== 1'b1 || r !== 32'h0 || l != 1) begin
      errors++;
      $display("FAIL rsvd_size: err=%b rdata=%h lat=%0d, required 1 00000000 1", e, r, l);
    end
    do_req(1'b0, 2'b10, 1'b0, DEPTH_WORDS * 4 - 2, 32'h0, r, e, l, w);
    checks++;
    if (e !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL top_overrun: err=%b rdata=%h, required 1 00000000", e, r);
    end
    do_req(1'b1, 2'b10, 1'b0, DEPTH_WORDS * 4 - 4, 32'h01020304, r, e, l, w);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL top_word_store: err=%b, required 0", e);
    end
    do_req(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h000000AA, r, e, l, w);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL st_byte_ffffffff: err=%b, required 1", e);
    end
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFFFFFE, 32'h0000BBBB, r, e, l, w);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL st_half_fffffffe: err=%b, required 1", e);
    end
    do_req(1'b0, 2'b10, 1'b0, DEPTH_WORDS * 4 - 4, 32'h0, r, e, l, w);
    checks++;
    if (e !== 1'b0 || r !== 32'h01020304) begin
      errors++;
      $display("FAIL top_word_intact: err=%b rdata=%h, required 0 01020304", e, r);
    end
    do_req(1'b0, 2'b00, 1'b1, DEPTH_WORDS * 4 - 1, 32'h0, r, e, l, w);
    checks++;
    if (e !== 1'b0 || r !== 32'h00000001) begin
      errors++;
      $display("FAIL last_byte: err=%b rdata=%h, required 0 00000001", e, r);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic e; int l; int w;
    logic [31:0] r0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_before: req_ready=%b, required 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    r0 = rsp_rdata;
    checks++;
    if (rsp_valid !== 1'b1 || r0 !== 32'h334455EF) begin
      errors++;
      $display("FAIL bp_first_rsp: valid=%b rdata=%h, required 1 334455ef", rsp_valid, r0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h334455EF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b, required 1 334455ef 0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0 1", rsp_valid, req_ready);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, r, e, l, w);
    checks++;
    if (w != 0 || l != 1 || r !== 32'h000000EF) begin
      errors++;
      $display("FAIL bp_next_req: wait=%0d lat=%0d rdata=%h, required 0 1 000000ef", w, l, r);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; logic e; int l; int w;
    do_req(1'b1, 2'b00, 1'b0, 32'h300, 32'h0000005A, r, e, l, w);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h100; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_resp: rsp_valid=%b, required 1", rsp_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_resp: valid=%b ready=%b, required 0 0", rsp_valid, req_ready);
    end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_release: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h300, 32'h0, r, e, l, w);
    checks++;
    if (r !== 32'h0000005A) begin
      errors++;
      $display("FAIL rst_persist_byte: rdata=%h, required 0000005a", r);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, e, l, w);
    checks++;
    if (r !== 32'h334455EF) begin
      errors++;
      $display("FAIL rst_persist_word: rdata=%h, required 334455ef", r);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extension();
    test_store_mask();
    test_crossing();
    test_errors();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RV32I core's load/store unit. It owns the byte-addressed data store and serves one request at a time over a valid/ready request channel and a valid/ready response channel.
- Handles byte, halfword and word accesses, including misaligned accesses that cross a word boundary.
- Loads are sign- or zero-extended; stores are byte-masked.

Parameters:
- DEPTH_WORDS, 32768, number of 32-bit words in the store; byte address range is 0 .. DEPTH_WORDS*4-1.
- IDX_W, $clog2(DEPTH_WORDS), word-index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved.
- req_unsigned  in  1  load zero-extends when 1 (ignored for stores and for word loads).
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access fault (range, reserved size, misaligned when split is disabled).

Behaviour:
- Reset: clk and rst_n as stated above. During reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM to IDLE. Memory contents are not cleared.
- FSM states: IDLE, SECOND, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&&req_ready and capture the request.
  - On the accept edge, access the first word, index addr[IDX_W+1:2]: read its bytes into a holding register, or write its bytes under byte mask.
  - If the access crosses a word boundary (addr[1:0]+bytes>4), go to SECOND; otherwise go to RESP.
- SECOND:
  - Access word index+1 for the remaining bytes; go to RESP.
  - Byte k of the access lives at byte lane (addr[1:0]+k) mod 4.
- RESP:
  - rsp_valid=1, with rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready.
  - On handshake, return to IDLE.
  - req_ready=0 in SECOND and RESP; no request overlap.
- Latency: rsp_valid rises 1 cycle after accept for non-crossing accesses, 2 cycles after for crossing ones. Back-to-back requests achieve 1 request per 2 cycles minimum.
- Load extension:
  - Byte: bit7 replicated to [31:8] unless req_unsigned.
  - Half: bit15 replicated to [31:16] unless req_unsigned.
  - Word: unchanged.
- Store: write only req_wdata[8*n-1:0], where n is the access size in bytes; other bytes are untouched.
- Errors are detected at accept. There is no memory side effect and no SECOND state; go directly to RESP with rsp_err=1 and rsp_rdata=0. Error conditions:
  - req_size=11;
  - last byte address (addr+n-1) >= DEPTH_WORDS*4, including 32-bit overflow.
- No wrap-around past the top of memory: such an access is a range error.
- Reset asserted in SECOND: the second-word write is abandoned (the first word has already been written) and no response is produced.
- Reset asserted in RESP: the response is dropped.
- rsp_ready held high in IDLE has no effect.

Optional Feature:
- Macro DMEM_MISALIGN_SPLIT_EN.
- Defined: word-crossing accesses are split through SECOND as described above.
- Undefined:
  - Any access with addr not a multiple of n (half: addr[0]!=0; word: addr[1:0]!=0) is an error response with no side effect.
  - The SECOND state is not built.
  - Aligned latency is unchanged.

Decomposition:
- Package rv32i_mem_pkg holds:
  - typedef enum logic[1:0] mem_size_e {MEM_B, MEM_H, MEM_W, MEM_RSVD};
  - typedef enum dmem_state_e {DMEM_IDLE, DMEM_SECOND, DMEM_RESP};
  - function mem_size_bytes(mem_size_e) returning 1/2/4.
- One combinational sub-module, dmem_lane_align: takes 4 assembled bytes, size and unsigned flag, and returns extended rdata; it also generates per-lane store bytes and masks from addr[1:0]/size/wdata.

Test Plan:
- Aligned word store then load: store addr=0x100, wdata=0xDEADBEEF -> rsp 1 cycle after accept, err=0. Load word 0x100 -> rdata=0xDEADBEEF.
- Byte/half extension: load byte at 0x103 -> 0xFFFFFFDE. Same with unsigned -> 0x000000DE. Load half at 0x102 signed -> 0xFFFFDEAD.
- Crossing word (SPLIT_EN defined):
  - Store word 0x12345678 at 0x202 -> rsp 2 cycles after accept. Word 0x200 bytes[3:2]=0x78,0x56; word 0x204 bytes[1:0]=0x34,0x12.
  - Load word 0x202 -> 0x12345678.
  - Without the macro, the same store gives err=1 and memory is unchanged.
- Errors: size=11 -> err=1, rdata=0. Load word at DEPTH_WORDS*4-2 -> err=1. Store byte at 0xFFFFFFFF -> err=1 with no write.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable and req_ready=0 throughout; release -> IDLE, next request accepted the following cycle.
- Reset mid-op: assert rst_n=0 while in RESP -> next cycle rsp_valid=0, req_ready=0; after release req_ready=1 and earlier completed stores persist.
